asteroid_engine: RTL and testbench

ASTEROID_ENGINE -- requirements
Module: asteroid_engine

---
 rtl/asteroid_pkg.sv | 26 ++
 rtl/asteroid_if.sv | 26 ++
 rtl/asteroid_tick_divider.sv | 33 +++
 rtl/asteroid_engine.sv | 146 ++++++++++++++
 tb/tb_asteroid_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asteroid_pkg.sv
// asteroid_pkg -- shared definitions for the asteroid engine.
//   Direction field codes, FSM state type and the direction-validity check.
//   A 4-bit direct word is {x_field[1:0], y_field[1:0]}.
package asteroid_pkg;

    // x-field codes (direct[3:2])
    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_POS_X = 2'b01;
    localparam logic [1:0] DIR_NEG_X = 2'b10;
    // y-field codes (direct[1:0]); screen y grows downward, so 01 moves up
    localparam logic [1:0] DIR_NEG_Y = 2'b01;
    localparam logic [1:0] DIR_POS_Y = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } state_t;

    // A direction is usable when neither field holds the reserved 11 code
    // and at least one axis actually moves.
    function automatic logic dir_valid(input logic [3:0] d);
        return (d[3:2] != 2'b11) && (d[1:0] != 2'b11) &&
               ((d[3:2] != DIR_NONE) || (d[1:0] != DIR_NONE));
    endfunction

endpackage

// File: rtl/asteroid_if.sv
// asteroid_if -- control/status bundle between a controller and the engine.
//   start, direct, kill, pause : controller -> engine
//   moving, origin_x, origin_y, done : engine -> controller
interface asteroid_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) ();
    logic           start;
    logic [3:0]     direct;
    logic           kill;
    logic           pause;
    logic           moving;
    logic [X_W-1:0] origin_x;
    logic [Y_W-1:0] origin_y;
    logic           done;

    modport master (
        output start, direct, kill, pause,
        input  moving, origin_x, origin_y, done
    );

    modport slave (
        input  start, direct, kill, pause,
        output moving, origin_x, origin_y, done
    );
endinterface

// File: rtl/asteroid_tick_divider.sv
// tick_divider -- movement tick timer (down-counter, terminal count at 0).
//   clk, reset : clock and async active-low reset (count clears to 0)
//   load       : restart the interval (count <= TICK_DIV-1)
//   enable     : count this clock; frozen while low
//   tick       : high on the enabled clock where the count is 0 (it reloads)
module tick_divider #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic tick
);
    // TICK_DIV = 1 would give a zero-width counter; keep one bit that stays 0.
    localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable) begin
            if (count == '0) count <= RELOAD;
            else             count <= count - CW'(1);
        end
    end

    assign tick = enable && (count == '0);
endmodule

// File: rtl/asteroid_engine.sv
// asteroid_engine -- spawns an object on a screen edge and steps it across.
//   clk, reset : system clock, async active-low reset
//   bus.start/direct : spawn request and direction (sampled in IDLE)
//   bus.kill         : abort the flight (sampled in MOVING)
//   bus.pause        : freezes tick timer and position
//   bus.moving       : flight in progress
//   bus.origin_x/y   : current position, held in IDLE
//   bus.done         : one-cycle pulse when a flight ends
//
//   state  | meaning
//   IDLE   | waiting for start with a valid direction
//   MOVING | stepping STEP pixels every TICK_DIV clocks
module asteroid_engine
    import asteroid_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int STEP     = 3,
    parameter int TICK_DIV = 2500000,
    parameter int WRAP     = 0
) (
    input  logic     clk,
    input  logic     reset,
    asteroid_if.slave bus
);
    localparam logic [X_W:0]   STEP_X = (X_W + 1)'(STEP);
    localparam logic [Y_W:0]   STEP_Y = (Y_W + 1)'(STEP);
    localparam logic [X_W:0]   SPAN_X = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]   SPAN_Y = (Y_W + 1)'(SCREEN_H);
    localparam logic [X_W:0]   MAX_X  = (X_W + 1)'(SCREEN_W - 1);
    localparam logic [Y_W:0]   MAX_Y  = (Y_W + 1)'(SCREEN_H - 1);
    localparam logic [X_W-1:0] LAST_X = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] MID_X  = X_W'(SCREEN_W / 2 - 1);
    localparam logic [Y_W-1:0] MID_Y  = Y_W'(SCREEN_H / 2 - 1);

    state_t         state_q, state_d;
    logic [3:0]     dir_q, dir_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           done_q, done_d;

    logic           load, enable, tick;
    logic [X_W:0]   x_sum, x_fix;
    logic [Y_W:0]   y_sum, y_fix;
    logic           x_out, y_out;

    assign load   = (state_q == IDLE) && bus.start && dir_valid(bus.direct);
    assign enable = (state_q == MOVING) && !bus.pause;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .enable (enable),
        .tick   (tick)
    );

    // One extra bit: an underflow wraps to a value above 2^W, which the
    // single "> max" compare catches alongside an overflow.
    always_comb begin
        x_sum = {1'b0, x_q};
        case (dir_q[3:2])
            DIR_POS_X: x_sum = {1'b0, x_q} + STEP_X;
            DIR_NEG_X: x_sum = {1'b0, x_q} - STEP_X;
            default:   x_sum = {1'b0, x_q};
        endcase
        x_out = x_sum > MAX_X;
        x_fix = x_sum;
        if (x_out) x_fix = (dir_q[3:2] == DIR_NEG_X) ? x_sum + SPAN_X : x_sum - SPAN_X;

        y_sum = {1'b0, y_q};
        case (dir_q[1:0])
            DIR_POS_Y: y_sum = {1'b0, y_q} + STEP_Y;
            DIR_NEG_Y: y_sum = {1'b0, y_q} - STEP_Y;
            default:   y_sum = {1'b0, y_q};
        endcase
        y_out = y_sum > MAX_Y;
        y_fix = y_sum;
        if (y_out) y_fix = (dir_q[1:0] == DIR_NEG_Y) ? y_sum + SPAN_Y : y_sum - SPAN_Y;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    dir_d   = bus.direct;
                    state_d = MOVING;
                    case (bus.direct[3:2])
                        DIR_POS_X: x_d = '0;
                        DIR_NEG_X: x_d = LAST_X;
                        default:   x_d = MID_X;
                    endcase
                    case (bus.direct[1:0])
                        DIR_POS_Y: y_d = '0;
                        DIR_NEG_Y: y_d = LAST_Y;
                        default:   y_d = MID_Y;
                    endcase
                end
            end
            MOVING: begin
                if (bus.kill) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    if ((WRAP == 0) && (x_out || y_out)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        x_d = x_fix[X_W-1:0];
                        y_d = y_fix[Y_W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign bus.moving   = (state_q == MOVING);
    assign bus.origin_x = x_q;
    assign bus.origin_y = y_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_asteroid_engine.sv
// tb_asteroid_engine -- drives one despawning (WRAP=0) and one wrapping
// (WRAP=1) engine with identical stimulus and compares both against a
// plain-integer reference model, plus fixed expected positions.
module tb_asteroid_engine;
    localparam int TD = 4;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, kill = 1'b0, pause = 1'b0;
    logic [3:0] direct = 4'b0000;

    int vectors = 0;
    int miscompares = 0;

    asteroid_if #(.X_W(8), .Y_W(7)) bus0 ();
    asteroid_if #(.X_W(8), .Y_W(7)) bus1 ();

    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.direct = direct; assign bus1.direct = direct;
    assign bus0.kill = kill;    assign bus1.kill = kill;
    assign bus0.pause = pause;  assign bus1.pause = pause;

    asteroid_engine #(.TICK_DIV(TD), .WRAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    asteroid_engine #(.TICK_DIV(TD), .WRAP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    always #5 clk = ~clk;

    logic       mov_o[2];
    logic       done_o[2];
    logic [7:0] x_o[2];
    logic [6:0] y_o[2];
    assign mov_o[0] = bus0.moving;  assign mov_o[1] = bus1.moving;
    assign done_o[0] = bus0.done;   assign done_o[1] = bus1.done;
    assign x_o[0] = bus0.origin_x;  assign x_o[1] = bus1.origin_x;
    assign y_o[0] = bus0.origin_y;  assign y_o[1] = bus1.origin_y;

    // Reference model: index 0 despawns at the edge, index 1 wraps.
    bit         m_mov[2];
    bit         m_done[2];
    int         m_x[2], m_y[2], m_wait[2], m_dx[2], m_dy[2];

    function automatic bit ref_valid(input logic [3:0] d);
        int xf, yf;
        xf = int'(d) / 4;
        yf = int'(d) % 4;
        return (xf != 3) && (yf != 3) && !(xf == 0 && yf == 0);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_mov[m] = 0; m_done[m] = 0; m_x[m] = 0; m_y[m] = 0;
            m_wait[m] = 0; m_dx[m] = 0; m_dy[m] = 0;
        end
    endtask

    task automatic model_edge();
        int nx, ny;
        for (int m = 0; m < 2; m++) begin
            m_done[m] = 0;
            if (!m_mov[m]) begin
                if (start && ref_valid(direct)) begin
                    m_dx[m] = (direct[3:2] == 2'b01) ? ST : (direct[3:2] == 2'b10) ? -ST : 0;
                    m_dy[m] = (direct[1:0] == 2'b10) ? ST : (direct[1:0] == 2'b01) ? -ST : 0;
                    m_x[m] = (m_dx[m] > 0) ? 0 : (m_dx[m] < 0) ? W - 1 : W / 2 - 1;
                    m_y[m] = (m_dy[m] > 0) ? 0 : (m_dy[m] < 0) ? H - 1 : H / 2 - 1;
                    m_wait[m] = TD;
                    m_mov[m] = 1;
                end
            end else if (kill) begin
                m_mov[m] = 0;
                m_done[m] = 1;
            end else if (!pause) begin
                m_wait[m]--;
                if (m_wait[m] == 0) begin
                    m_wait[m] = TD;
                    nx = m_x[m] + m_dx[m];
                    ny = m_y[m] + m_dy[m];
                    if (m == 0 && (nx < 0 || nx >= W || ny < 0 || ny >= H)) begin
                        m_mov[m] = 0;
                        m_done[m] = 1;
                    end else begin
                        m_x[m] = (nx < 0) ? nx + W : (nx >= W) ? nx - W : nx;
                        m_y[m] = (ny < 0) ? ny + H : (ny >= H) ? ny - H : ny;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (mov_o[m] !== 1'b0 || done_o[m] !== 1'b0 || x_o[m] !== 8'd0 || y_o[m] !== 7'd0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got mov=%b done=%b x=%0d y=%0d, want 0 0 0 0",
                         m, mov_o[m], done_o[m], x_o[m], y_o[m]);
            end
        end
    endtask

    task automatic test_straight();
        start = 1; direct = 4'b0010;
        cycle();
        start = 0;
        vectors++;
        if (mov_o[0] !== 1'b1 || x_o[0] !== 8'd79 || y_o[0] !== 7'd0) begin
            miscompares++;
            $display("FAIL spawn_0010: got mov=%b (%0d,%0d), want 1 (79,0)", mov_o[0], x_o[0], y_o[0]);
        end
        repeat (4) cycle();
        vectors++;
        if (x_o[0] !== 8'd79 || y_o[0] !== 7'd3) begin
            miscompares++;
            $display("FAIL step1_0010: got (%0d,%0d), want (79,3)", x_o[0], y_o[0]);
        end
        repeat (4) cycle();
        vectors++;
        if (x_o[0] !== 8'd79 || y_o[0] !== 7'd6) begin
            miscompares++;
            $display("FAIL step2_0010: got (%0d,%0d), want (79,6)", x_o[0], y_o[0]);
        end
        kill = 1;
        cycle();
        kill = 0;
        vectors++;
        if (done_o[0] !== 1'b1 || mov_o[0] !== 1'b0 || x_o[0] !== 8'd79 || y_o[0] !== 7'd6) begin
            miscompares++;
            $display("FAIL kill_0010: got done=%b mov=%b (%0d,%0d), want 1 0 (79,6)",
                     done_o[0], mov_o[0], x_o[0], y_o[0]);
        end
        cycle();
    endtask

    task automatic test_exit();
        int pulses = 0;
        start = 1; direct = 4'b0110;
        cycle();
        start = 0;
        for (int c = 0; c < 200; c++) begin
            if (done_o[0] === 1'b1) pulses++;
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (mov_o[m] !== m_mov[m] || done_o[m] !== m_done[m] ||
                    x_o[m] !== 8'(m_x[m]) || y_o[m] !== 7'(m_y[m])) begin
                    miscompares++;
                    $display("FAIL exit_track dut%0d c=%0d: got mov=%b done=%b (%0d,%0d), want %b %b (%0d,%0d)",
                             m, c, mov_o[m], done_o[m], x_o[m], y_o[m], m_mov[m], m_done[m], m_x[m], m_y[m]);
                end
            end
            cycle();
        end
        vectors++;
        if (pulses != 1 || mov_o[0] !== 1'b0 || x_o[0] !== 8'd117 || y_o[0] !== 7'd117) begin
            miscompares++;
            $display("FAIL exit_0110: got pulses=%0d mov=%b (%0d,%0d), want 1 0 (117,117)",
                     pulses, mov_o[0], x_o[0], y_o[0]);
        end
        kill = 1;
        cycle();
        kill = 0;
        vectors++;
        if (done_o[0] !== 1'b0 || done_o[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_idle_ignored: got done0=%b done1=%b, want 0 1", done_o[0], done_o[1]);
        end
        cycle();
        direct = 4'b0000;
    endtask

    task automatic test_wrap();
        start = 1; direct = 4'b1000;
        cycle();
        start = 0;
        vectors++;
        if (x_o[1] !== 8'd159 || y_o[1] !== 7'd59) begin
            miscompares++;
            $display("FAIL spawn_1000: got (%0d,%0d), want (159,59)", x_o[1], y_o[1]);
        end
        repeat (53 * TD) cycle();
        vectors++;
        if (x_o[1] !== 8'd0 || mov_o[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_reach0: got x=%0d mov=%b, want 0 1", x_o[1], mov_o[1]);
        end
        repeat (TD) cycle();
        vectors++;
        if (x_o[1] !== 8'd157 || mov_o[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_157: got x=%0d mov=%b, want 157 1", x_o[1], mov_o[1]);
        end
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (mov_o[m] !== m_mov[m] || x_o[m] !== 8'(m_x[m]) || y_o[m] !== 7'(m_y[m])) begin
                miscompares++;
                $display("FAIL wrap_model dut%0d: got mov=%b (%0d,%0d), want %b (%0d,%0d)",
                         m, mov_o[m], x_o[m], y_o[m], m_mov[m], m_x[m], m_y[m]);
            end
        end
        kill = 1;
        cycle();
        kill = 0;
        cycle();
    endtask

    task automatic test_kill_on_step();
        logic [3:0] bad [5];
        int pulses = 0;
        bad[0] = 4'b1100; bad[1] = 4'b0000; bad[2] = 4'b0011; bad[3] = 4'b1111; bad[4] = 4'b1101;
        start = 1; direct = 4'b0101;
        cycle();
        start = 0;
        repeat (TD - 1) cycle();
        kill = 1;
        cycle();
        kill = 0;
        vectors++;
        if (x_o[0] !== 8'd0 || y_o[0] !== 7'd119 || done_o[0] !== 1'b1 || mov_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_on_step: got (%0d,%0d) done=%b mov=%b, want (0,119) 1 0",
                     x_o[0], y_o[0], done_o[0], mov_o[0]);
        end
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (done_o[0] === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL kill_single_pulse: got %0d extra pulses, want 0", pulses);
        end
        for (int i = 0; i < 5; i++) begin
            start = 1; direct = bad[i];
            cycle();
            vectors++;
            if (mov_o[0] !== 1'b0 || mov_o[1] !== 1'b0 || x_o[0] !== 8'd0 || y_o[0] !== 7'd119) begin
                miscompares++;
                $display("FAIL invalid_start %b: got mov=%b/%b (%0d,%0d), want 0/0 (0,119)",
                         bad[i], mov_o[0], mov_o[1], x_o[0], y_o[0]);
            end
        end
        start = 0; direct = 4'b0000;
        cycle();
    endtask

    task automatic test_pause();
        start = 1; direct = 4'b0100;
        cycle();
        start = 0;
        repeat (2) cycle();
        pause = 1;
        repeat (10) cycle();
        pause = 0;
        vectors++;
        if (x_o[0] !== 8'd0 || mov_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_freeze: got x=%0d mov=%b, want 0 1", x_o[0], mov_o[0]);
        end
        cycle();
        vectors++;
        if (x_o[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL pause_early: got x=%0d, want 0", x_o[0]);
        end
        cycle();
        vectors++;
        if (x_o[0] !== 8'd3 || y_o[0] !== 7'd59) begin
            miscompares++;
            $display("FAIL pause_step: got (%0d,%0d), want (3,59)", x_o[0], y_o[0]);
        end
        pause = 1; kill = 1;
        cycle();
        pause = 0; kill = 0;
        vectors++;
        if (done_o[0] !== 1'b1 || mov_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_while_paused: got done=%b mov=%b, want 1 0", done_o[0], mov_o[0]);
        end
        cycle();
    endtask

    task automatic test_reset_midflight();
        start = 1; direct = 4'b0101;
        cycle();
        start = 0;
        repeat (6) cycle();
        #2;
        reset = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (mov_o[m] !== 1'b0 || x_o[m] !== 8'd0 || y_o[m] !== 7'd0 || done_o[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got mov=%b done=%b (%0d,%0d), want 0 0 (0,0)",
                         m, mov_o[m], done_o[m], x_o[m], y_o[m]);
            end
        end
        model_reset();
        start = 1; direct = 4'b1001;
        @(negedge clk);
        reset = 1;
        cycle();
        start = 0;
        vectors++;
        if (mov_o[0] !== 1'b1 || x_o[0] !== 8'd159 || y_o[0] !== 7'd119) begin
            miscompares++;
            $display("FAIL first_start: got mov=%b (%0d,%0d), want 1 (159,119)", mov_o[0], x_o[0], y_o[0]);
        end
        kill = 1;
        cycle();
        kill = 0;
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            start  = ($urandom_range(0, 3) == 0);
            direct = 4'($urandom_range(0, 15));
            kill   = ($urandom_range(0, 39) == 0);
            pause  = ($urandom_range(0, 7) == 0);
            cycle();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (mov_o[m] !== m_mov[m] || done_o[m] !== m_done[m] ||
                    x_o[m] !== 8'(m_x[m]) || y_o[m] !== 7'(m_y[m])) begin
                    miscompares++;
                    $display("FAIL random dut%0d c=%0d: got mov=%b done=%b (%0d,%0d), want %b %b (%0d,%0d)",
                             m, c, mov_o[m], done_o[m], x_o[m], y_o[m], m_mov[m], m_done[m], m_x[m], m_y[m]);
                end
            end
        end
        start = 0; kill = 0; pause = 0; direct = 4'b0000;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1;
        test_reset();
        test_straight();
        test_exit();
        test_wrap();
        test_kill_on_step();
        test_pause();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
